// File: rtl/instr_dispatch_queue.sv
// Circular in-order instruction queue feeding the Add/Sub and Mul/Div reservation stations.
// Optional synchronous queue flush is enabled with the INSTRQ_FLUSH_EN macro.
module instr_dispatch_queue #(
    parameter int INSTR_W = 9,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               Clock,
    input  logic               Clear,
`ifdef INSTRQ_FLUSH_EN
    input  logic               Flush,
`endif
    input  logic               add,
    input  logic [INSTR_W-1:0] instrIn,
    input  logic               remove,
    input  logic               RS_AddSubFull,
    input  logic               RS_MulDivFull,
    output logic [INSTR_W-1:0] instrOut,
    output logic               dispValid,
    output logic               toAddSub,
    output logic               toMulDiv,
    output logic               illegal,
    output logic               stall,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [INSTR_W-1:0] head_instr;
    logic               flush;
    logic               is_illegal;
    logic               to_as;
    logic               to_md;
    logic               rs_full;
    logic               do_disp;
    logic               do_stall;
    logic               do_enq;
    logic [CNT_W-1:0]   count_nxt;

`ifdef INSTRQ_FLUSH_EN
    assign flush = Flush;
`else
    assign flush = 1'b0;
`endif

    // Decode is done on the head entry; the top opcode bit alone marks an illegal instruction.
    always_comb begin
        head_instr = mem[head];
        is_illegal = head_instr[INSTR_W-1];
        to_as      = ~head_instr[INSTR_W-1] & ~head_instr[INSTR_W-2];
        to_md      = ~head_instr[INSTR_W-1] &  head_instr[INSTR_W-2];
        rs_full    = to_as ? RS_AddSubFull : RS_MulDivFull;
        do_disp    = ~flush & remove & ~empty & (is_illegal | ~rs_full);
        do_stall   = ~flush & remove & ~empty & ~is_illegal & rs_full;
        do_enq     = ~flush & add & (~full | do_disp);
        unique case ({do_enq, do_disp})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (do_enq) begin
            mem[tail] <= instrIn;
        end
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            instrOut  <= '1;
            dispValid <= 1'b0;
            toAddSub  <= 1'b0;
            toMulDiv  <= 1'b0;
            illegal   <= 1'b0;
            stall     <= 1'b0;
        end else begin
            dispValid <= 1'b0;
            toAddSub  <= 1'b0;
            toMulDiv  <= 1'b0;
            illegal   <= 1'b0;
            stall     <= 1'b0;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                empty <= 1'b1;
                full  <= 1'b0;
            end else begin
                if (do_enq) begin
                    tail <= tail + PTR_W'(1);
                end
                if (do_disp) begin
                    head <= head + PTR_W'(1);
                end
                count <= count_nxt;
                full  <= (count_nxt == CNT_W'(DEPTH));
                empty <= (count_nxt == '0);
                if (do_disp && !is_illegal) begin
                    instrOut  <= head_instr;
                    dispValid <= 1'b1;
                    toAddSub  <= to_as;
                    toMulDiv  <= to_md;
                end
                illegal <= do_disp & is_illegal;
                stall   <= do_stall;
            end
        end
    end

endmodule

// File: tb/tb_instr_dispatch_queue.sv
// Directed bench for instr_dispatch_queue with hand-computed expectations.
module tb_instr_dispatch_queue;

    logic       Clock = 1'b0;
    logic       Clear;
    logic       add;
    logic [8:0] instrIn;
    logic       remove;
    logic       RS_AddSubFull;
    logic       RS_MulDivFull;
    logic [8:0] instrOut;
    logic       dispValid;
    logic       toAddSub;
    logic       toMulDiv;
    logic       illegal;
    logic       stall;
    logic       full;
    logic       empty;
    logic [3:0] count;
`ifdef INSTRQ_FLUSH_EN
    logic       Flush = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] vals_a [8];
    logic [8:0] vals_b [8];

    instr_dispatch_queue dut (
        .Clock(Clock),
        .Clear(Clear),
`ifdef INSTRQ_FLUSH_EN
        .Flush(Flush),
`endif
        .add(add),
        .instrIn(instrIn),
        .remove(remove),
        .RS_AddSubFull(RS_AddSubFull),
        .RS_MulDivFull(RS_MulDivFull),
        .instrOut(instrOut),
        .dispValid(dispValid),
        .toAddSub(toAddSub),
        .toMulDiv(toMulDiv),
        .illegal(illegal),
        .stall(stall),
        .full(full),
        .empty(empty),
        .count(count)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic enq(input logic [8:0] v);
        add = 1'b1;
        instrIn = v;
        tick();
        add = 1'b0;
    endtask

    // Expected routing from an opcode: 0,1 -> Add/Sub, 2,3 -> Mul/Div.
    task automatic check_disp(input string tag, input logic [8:0] v);
        check({tag, "_out"}, 32'(instrOut), 32'(v));
        check({tag, "_valid"}, 32'(dispValid), 32'd1);
        check({tag, "_as"}, 32'(toAddSub), 32'(v[8:7] == 2'b00));
        check({tag, "_md"}, 32'(toMulDiv), 32'(v[8:7] == 2'b01));
    endtask

    initial begin
        Clear = 1'b0;
        add = 1'b0;
        instrIn = '0;
        remove = 1'b0;
        RS_AddSubFull = 1'b0;
        RS_MulDivFull = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vals_a[i] = {3'(i % 4), 6'(i + 10)};
            vals_b[i] = {3'((i + 1) % 4), 6'(i + 40)};
        end

        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_out", 32'(instrOut), 32'h1FF);
        check("rst_pulses", 32'({dispValid, toAddSub, toMulDiv, illegal, stall}), 32'd0);
        tick();
        Clear = 1'b1;
        tick();

        // Basic ADD / MUL / SUB ordering
        enq(9'o012);
        enq(9'o245);
        enq(9'o101);
        check("basic_count", 32'(count), 32'd3);
        remove = 1'b1;
        tick(); check_disp("basic0", 9'o012);
        tick(); check_disp("basic1", 9'o245);
        tick(); check_disp("basic2", 9'o101);
        check("basic_empty", 32'(empty), 32'd1);
        remove = 1'b0;
        tick();
        check("basic_idle_valid", 32'(dispValid), 32'd0);

        // Fill, then overflow attempt
        for (int i = 0; i < 8; i++) enq(vals_a[i]);
        check("fill_count", 32'(count), 32'd8);
        check("fill_full", 32'(full), 32'd1);
        enq(9'o077);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_full", 32'(full), 32'd1);

        // Full queue, simultaneous enqueue and dispatch across pointer wrap
        remove = 1'b1;
        add = 1'b1;
        for (int i = 0; i < 8; i++) begin
            instrIn = vals_b[i];
            tick();
            check_disp($sformatf("wrap%0d", i), vals_a[i]);
            check($sformatf("wrap%0d_count", i), 32'(count), 32'd8);
            check($sformatf("wrap%0d_stall", i), 32'(stall), 32'd0);
        end
        add = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_disp($sformatf("drain%0d", i), vals_b[i]);
        end
        remove = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(count), 32'd0);

        // Stall on full Mul/Div station
        enq(9'o301);
        enq(9'o055);
        RS_MulDivFull = 1'b1;
        remove = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d", i), 32'(stall), 32'd1);
            check($sformatf("stall%0d_valid", i), 32'(dispValid), 32'd0);
            check($sformatf("stall%0d_count", i), 32'(count), 32'd2);
        end
        RS_MulDivFull = 1'b0;
        tick();
        check_disp("unstall", 9'o301);
        check("unstall_stall", 32'(stall), 32'd0);
        check("unstall_count", 32'(count), 32'd1);
        RS_AddSubFull = 1'b1;
        tick();
        check("as_stall", 32'(stall), 32'd1);
        RS_AddSubFull = 1'b0;
        tick();
        check_disp("as_go", 9'o055);
        tick();
        check("rm_empty_pulses", 32'({dispValid, toAddSub, toMulDiv, illegal, stall}), 32'd0);
        remove = 1'b0;

        // Illegal opcode discard
        enq(9'o600);
        enq(9'o033);
        remove = 1'b1;
        tick();
        check("ill_pulse", 32'(illegal), 32'd1);
        check("ill_valid", 32'(dispValid), 32'd0);
        check("ill_count", 32'(count), 32'd1);
        check("ill_out", 32'(instrOut), 32'(9'o055));
        tick();
        check_disp("after_ill", 9'o033);
        check("after_ill_pulse", 32'(illegal), 32'd0);

        // Add together with remove on empty: no bypass
        add = 1'b1;
        instrIn = 9'o211;
        tick();
        add = 1'b0;
        check("nobyp_valid", 32'(dispValid), 32'd0);
        check("nobyp_count", 32'(count), 32'd1);
        tick();
        check_disp("nobyp_next", 9'o211);
        remove = 1'b0;
        tick();

        // Asynchronous clear with five entries queued
        for (int i = 0; i < 5; i++) enq(vals_a[i]);
        check("pre_clr_count", 32'(count), 32'd5);
        #2;
        Clear = 1'b0;
        #1;
        check("clr_count", 32'(count), 32'd0);
        check("clr_empty", 32'(empty), 32'd1);
        check("clr_out", 32'(instrOut), 32'h1FF);
        tick();
        Clear = 1'b1;
        remove = 1'b1;
        tick();
        check("post_clr_pulses", 32'({dispValid, toAddSub, toMulDiv, illegal, stall}), 32'd0);
        check("post_clr_empty", 32'(empty), 32'd1);
        remove = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
